// File: rtl/lvds_tx_7to1.sv
// lvds_tx_7to1: 7:1 FPD-Link/OpenLDI serializer for the LCD panel.
// One pixel (RGB + HS/VS/DE) per 7-cycle frame, three data lanes plus the
// clock lane. Define LVDS_TX_LANE3_EN to build the 24-bit variant with a
// fourth data lane carrying the top two bits of each colour.
module lvds_tx_7to1 (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  output logic        pix_ready,
`ifdef LVDS_TX_LANE3_EN
  input  logic [23:0] pix_rgb,
`else
  input  logic [17:0] pix_rgb,
`endif
  input  logic        pix_hs,
  input  logic        pix_vs,
  input  logic        pix_de,
`ifdef LVDS_TX_LANE3_EN
  output logic [3:0]  tx_data,
`else
  output logic [2:0]  tx_data,
`endif
  output logic        tx_clk,
  output logic        underrun,
  input  logic        underrun_clr
);

`ifdef LVDS_TX_LANE3_EN
  localparam int NL = 4;
  localparam int CW = 8;
`else
  localparam int NL = 3;
  localparam int CW = 6;
`endif
  localparam int RGBW = 3 * CW;
  // Clock-lane pattern, bit k is the level during slot k (1 1 0 0 0 1 1).
  localparam logic [6:0] CLK_PATTERN = 7'b1100011;

  logic [2:0]      ph_r;
  logic            hold_full_r;
  logic [RGBW-1:0] hold_rgb_r;
  logic            hold_hs_r;
  logic            hold_vs_r;
  logic            hold_de_r;
  logic            started_r;
  logic            last_hs_r;
  logic            last_vs_r;
  logic            underrun_r;
  logic            ready_r;
  logic [6:0]      clk_pat_r;
  logic [6:0]      sh_r [NL];

  logic            xfer_s;
  logic            load_s;
  logic            hold_wr_s;
  logic            underrun_set_s;
  logic            hold_full_nxt_s;
  logic            ready_nxt_s;
  logic [2:0]      ph_nxt_s;
  logic [RGBW-1:0] src_rgb_s;
  logic            src_hs_s;
  logic            src_vs_s;
  logic            src_de_s;
  logic [CW-1:0]   r_s;
  logic [CW-1:0]   g_s;
  logic [CW-1:0]   b_s;
  logic [6:0]      word_s [NL];

  // Handshake, phase advance and holding-register bookkeeping
  always_comb begin
    xfer_s          = pix_valid && ready_r;
    load_s          = (ph_r == 3'd6);
    ph_nxt_s        = load_s ? 3'd0 : (ph_r + 3'd1);
    underrun_set_s  = 1'b0;
    if (load_s) begin
      // Hold word (if any) leaves; a word arriving now stays only if the
      // hold was occupied, otherwise it goes straight to the shifters.
      hold_full_nxt_s = hold_full_r && xfer_s;
      hold_wr_s       = hold_full_r && xfer_s;
      underrun_set_s  = !hold_full_r && !xfer_s && started_r;
    end else begin
      hold_full_nxt_s = hold_full_r || xfer_s;
      hold_wr_s       = xfer_s;
    end
    ready_nxt_s = !hold_full_nxt_s || (ph_nxt_s == 3'd6);
  end

  // Word to load on the 6->0 edge: hold, bypassed input, or a blank frame
  always_comb begin
    src_rgb_s = '0;
    src_hs_s  = last_hs_r;
    src_vs_s  = last_vs_r;
    src_de_s  = 1'b0;
    if (hold_full_r) begin
      src_rgb_s = hold_rgb_r;
      src_hs_s  = hold_hs_r;
      src_vs_s  = hold_vs_r;
      src_de_s  = hold_de_r;
    end else if (xfer_s) begin
      src_rgb_s = pix_rgb;
      src_hs_s  = pix_hs;
      src_vs_s  = pix_vs;
      src_de_s  = pix_de;
    end else begin
      src_rgb_s = '0;
      src_de_s  = 1'b0;
    end
  end

  // Slot mapping; bit k of each word is transmitted in slot k
  always_comb begin
    r_s = src_rgb_s[RGBW-1 -: CW];
    g_s = src_rgb_s[2*CW-1 -: CW];
    b_s = src_rgb_s[CW-1:0];
    for (int i = 0; i < NL; i++) begin
      word_s[i] = 7'd0;
    end
    word_s[0] = {r_s[0], r_s[1], r_s[2], r_s[3], r_s[4], r_s[5], g_s[0]};
    word_s[1] = {g_s[1], g_s[2], g_s[3], g_s[4], g_s[5], b_s[0], b_s[1]};
    word_s[2] = {b_s[2], b_s[3], b_s[4], b_s[5], src_hs_s, src_vs_s, src_de_s};
`ifdef LVDS_TX_LANE3_EN
    word_s[3] = {r_s[6], r_s[7], g_s[6], g_s[7], b_s[6], b_s[7], 1'b0};
`endif
  end

  // Phase, holding register, shifters, clock pattern and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_r        <= 3'd6;
      hold_full_r <= 1'b0;
      hold_rgb_r  <= '0;
      hold_hs_r   <= 1'b0;
      hold_vs_r   <= 1'b0;
      hold_de_r   <= 1'b0;
      started_r   <= 1'b0;
      last_hs_r   <= 1'b0;
      last_vs_r   <= 1'b0;
      underrun_r  <= 1'b0;
      ready_r     <= 1'b0;
      clk_pat_r   <= 7'd0;
      for (int i = 0; i < NL; i++) begin
        sh_r[i] <= 7'd0;
      end
    end else begin
      ph_r        <= ph_nxt_s;
      hold_full_r <= hold_full_nxt_s;
      ready_r     <= ready_nxt_s;
      if (hold_wr_s) begin
        hold_rgb_r <= pix_rgb;
        hold_hs_r  <= pix_hs;
        hold_vs_r  <= pix_vs;
        hold_de_r  <= pix_de;
      end
      if (xfer_s) begin
        started_r <= 1'b1;
      end
      if (load_s) begin
        last_hs_r <= src_hs_s;
        last_vs_r <= src_vs_s;
        clk_pat_r <= CLK_PATTERN;
        for (int i = 0; i < NL; i++) begin
          sh_r[i] <= word_s[i];
        end
      end else begin
        clk_pat_r <= {clk_pat_r[0], clk_pat_r[6:1]};
        for (int i = 0; i < NL; i++) begin
          sh_r[i] <= {1'b0, sh_r[i][6:1]};
        end
      end
      // A new empty frame outranks a simultaneous clear
      if (underrun_set_s) begin
        underrun_r <= 1'b1;
      end else if (underrun_clr) begin
        underrun_r <= 1'b0;
      end
    end
  end

  // Lane outputs are the LSB flops of the shift registers
  always_comb begin
    tx_data = '0;
    for (int i = 0; i < NL; i++) begin
      tx_data[i] = sh_r[i][0];
    end
  end

  assign tx_clk    = clk_pat_r[0];
  assign underrun  = underrun_r;
  assign pix_ready = ready_r;

endmodule

// File: tb/tb_lvds_tx_7to1.sv
// Directed bench for lvds_tx_7to1 with a per-cycle reference model.
// Builds for either lane configuration (LVDS_TX_LANE3_EN).
module tb_lvds_tx_7to1;
`ifdef LVDS_TX_LANE3_EN
  localparam int TW = 4;
  localparam int RW = 24;
`else
  localparam int TW = 3;
  localparam int RW = 18;
`endif

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } pix_t;

  logic          clk, rst, pix_valid, pix_ready, pix_hs, pix_vs, pix_de;
  logic          tx_clk, underrun, underrun_clr;
  logic [RW-1:0] pix_rgb;
  logic [TW-1:0] tx_data;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int   ph_m = 6;
  pix_t q_m[$];
  pix_t cur_m;
  pix_t drv_p;
  bit   in_frame_m, started_m, underrun_m, rdy_m, last_hs_m, last_vs_m, last_xf;
  logic [6:0] clkp = 7'b1100011;
  logic [0:6] l0_exp = 7'b1101010;
  logic [0:6] l1_exp = 7'b1101010;
  logic [0:6] l2_exp = 7'b1011111;
  logic [0:6] l3_exp = 7'b0011011;

  lvds_tx_7to1 dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_rgb(pix_rgb), .pix_hs(pix_hs), .pix_vs(pix_vs), .pix_de(pix_de),
    .tx_data(tx_data), .tx_clk(tx_clk), .underrun(underrun),
    .underrun_clr(underrun_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_slot(input pix_t p, input int k);
    logic [3:0] d;
    d = 4'd0;
    case (k)
      0: d = {1'b0,   p.de,   p.b[1], p.g[0]};
      1: d = {p.b[7], p.vs,   p.b[0], p.r[5]};
      2: d = {p.b[6], p.hs,   p.g[5], p.r[4]};
      3: d = {p.g[7], p.b[5], p.g[4], p.r[3]};
      4: d = {p.g[6], p.b[4], p.g[3], p.r[2]};
      5: d = {p.r[7], p.b[3], p.g[2], p.r[1]};
      6: d = {p.r[6], p.b[2], p.g[1], p.r[0]};
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  task automatic drive(input pix_t p);
    drv_p  = p;
    pix_hs = p.hs;
    pix_vs = p.vs;
    pix_de = p.de;
`ifdef LVDS_TX_LANE3_EN
    pix_rgb = {p.r, p.g, p.b};
`else
    pix_rgb = {p.r[5:0], p.g[5:0], p.b[5:0]};
`endif
  endtask

  function automatic pix_t mkpix(input int n);
    pix_t p;
    p.r  = n[7:0];
    p.g  = n[7:0] + 8'd37;
    p.b  = ~n[7:0];
    p.hs = n[0];
    p.vs = n[1];
    p.de = 1'b1;
    return p;
  endfunction

  // one clock: advance the model alongside the DUT and compare all outputs
  task automatic step();
    bit xf, clr, set;
    logic [3:0] e4;
    logic [TW-1:0] ed;
    xf  = pix_valid && rdy_m;
    clr = underrun_clr;
    if (xf) q_m.push_back(drv_p);
    @(posedge clk);
    #1;
    last_xf = xf;
    if (rst) begin
      ph_m = 6; q_m.delete(); started_m = 0; last_hs_m = 0; last_vs_m = 0;
      underrun_m = 0; rdy_m = 0; in_frame_m = 0; last_xf = 0;
    end else begin
      set  = 0;
      ph_m = (ph_m == 6) ? 0 : ph_m + 1;
      if (ph_m == 0) begin
        if (q_m.size() > 0) begin
          cur_m = q_m.pop_front();
        end else begin
          cur_m    = '0;
          cur_m.hs = last_hs_m;
          cur_m.vs = last_vs_m;
          set      = started_m;
        end
        last_hs_m  = cur_m.hs;
        last_vs_m  = cur_m.vs;
        in_frame_m = 1;
      end
      if (xf) started_m = 1;
      if (set) underrun_m = 1;
      else if (clr) underrun_m = 0;
      rdy_m = (q_m.size() == 0) || (ph_m == 6);
    end
    e4 = in_frame_m ? ref_slot(cur_m, ph_m) : 4'd0;
    ed = e4[TW-1:0];
    check("tx_data", 32'(tx_data), 32'(ed));
    check("tx_clk", 32'(tx_clk), in_frame_m ? 32'(clkp[ph_m]) : 32'd0);
    check("underrun", 32'(underrun), 32'(underrun_m));
    check("pix_ready", 32'(pix_ready), 32'(rdy_m));
  endtask

  task automatic wait_ph6();
    for (int i = 0; i < 8 && ph_m != 6; i++) step();
  endtask

  initial begin
    pix_t p;
    int cnt;
    int nx;
    rst = 1'b1; pix_valid = 1'b0; underrun_clr = 1'b0;
    drive('0);

    // reset held 5 cycles
    repeat (5) step();
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_clk", 32'(tx_clk), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);

    // release, idle frames
    rst = 1'b0;
    step();
    check("first_ready", 32'(pix_ready), 32'd1);
    check("first_clk", 32'(tx_clk), 32'd1);
    for (int i = 0; i < 14; i++) begin
      step();
      check("idle_clk", 32'(tx_clk), 32'(clkp[ph_m]));
      check("idle_data", 32'(tx_data), 32'd0);
      check("idle_underrun", 32'(underrun), 32'd0);
    end

    // single pixel accepted at ph==6
    wait_ph6();
    p.r = 8'h2A; p.g = 8'h15; p.b = 8'h3F; p.hs = 1'b1; p.vs = 1'b0; p.de = 1'b1;
    drive(p);
    pix_valid = 1'b1;
    check("ph6_ready", 32'(pix_ready), 32'd1);
    step();
    pix_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check("px_lane0", 32'(tx_data[0]), 32'(l0_exp[k]));
      check("px_lane1", 32'(tx_data[1]), 32'(l1_exp[k]));
      check("px_lane2", 32'(tx_data[2]), 32'(l2_exp[k]));
      if (k < 6) step();
    end
    // next frame is blank with HS held, underrun set
    step();
    check("blank_underrun", 32'(underrun), 32'd1);
    check("blank_de", 32'(tx_data[2]), 32'd0);
    step(); step();
    check("blank_hs_held", 32'(tx_data[2]), 32'd1);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("clr_underrun", 32'(underrun), 32'd0);
    wait_ph6();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("set_wins", 32'(underrun), 32'd1);

    // three pixels then stop
    rst = 1'b1; step(); rst = 1'b0; step();
    nx = 0;
    p = mkpix(1); p.hs = 1'b0; p.vs = 1'b0; drive(p);
    pix_valid = 1'b1;
    for (int c = 0; c < 40 && nx < 3; c++) begin
      step();
      if (last_xf) begin
        nx++;
        p = mkpix(nx + 1);
        p.hs = (nx == 2); p.vs = (nx == 2);
        drive(p);
      end
    end
    pix_valid = 1'b0;
    check("three_xfers", 32'(nx), 32'd3);
    repeat (7) step();
    check("pre_blank_underrun", 32'(underrun), 32'd0);
    repeat (7) step();
    check("fourth_blank_underrun", 32'(underrun), 32'd1);
    check("fourth_blank_de", 32'(tx_data[2]), 32'd0);
    step();
    check("fourth_blank_vs", 32'(tx_data[2]), 32'd1);

    // reset mid-frame with the holding register full
    rst = 1'b1; step(); rst = 1'b0; step();
    p = mkpix(99); drive(p);
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    step(); step();
    check("pre_rst_ph", 32'(ph_m), 32'd3);
    rst = 1'b1;
    step();
    check("mid_rst_data", 32'(tx_data), 32'd0);
    check("mid_rst_clk", 32'(tx_clk), 32'd0);
    check("mid_rst_ready", 32'(pix_ready), 32'd0);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      step();
      check("discarded", 32'(tx_data), 32'd0);
    end

    // continuous streaming, 1000 frames
    rst = 1'b1; step(); rst = 1'b0;
    cnt = 0;
    drive(mkpix(cnt));
    pix_valid = 1'b1;
    for (int c = 0; c < 7000; c++) begin
      step();
      if (last_xf) begin
        cnt++;
        drive(mkpix(cnt));
      end
    end
    pix_valid = 1'b0;
    check("stream_xfers", 32'(cnt), 32'd1000);
    check("stream_underrun", 32'(underrun), 32'd0);

`ifdef LVDS_TX_LANE3_EN
    // lane 3 mapping
    wait_ph6();
    p.r = 8'hC0; p.g = 8'h80; p.b = 8'h40; p.hs = 1'b0; p.vs = 1'b0; p.de = 1'b1;
    drive(p);
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check("lane3", 32'(tx_data[3]), 32'(l3_exp[k]));
      if (k < 6) step();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
